// File: rtl/port_arbiter_if.sv
// Requester-side and downstream-side signals of the three-port packet arbiter.
// The master modport is the requester/sink environment; the slave modport is the arbiter.
interface port_arbiter_if;
  logic [2:0]      R_req;
  logic [2:0][5:0] R_length;
  logic [2:0]      R_start;
  logic [2:0][7:0] R_data;
  logic [2:0]      R_end;
  logic [2:0]      R_grant;

  logic       O_valid;
  logic       O_start;
  logic       O_end;
  logic [7:0] O_data;
  logic [5:0] O_length;

  modport master (
    output R_req, R_length, R_start, R_data, R_end,
    input  R_grant, O_valid, O_start, O_end, O_data, O_length
  );

  modport slave (
    input  R_req, R_length, R_start, R_data, R_end,
    output R_grant, O_valid, O_start, O_end, O_data, O_length
  );
endinterface

// File: rtl/port_arbiter.sv
// Round-robin arbiter forwarding one packet at a time from three requesters downstream.
// Optional grant-to-start watchdog enabled by defining PORT_ARBITER_TIMEOUT_EN.
module port_arbiter #(
  parameter int TIMEOUT   = 16,
  parameter int MAXLENGTH = 12
) (
  input  logic             clk,
  input  logic             reset,
  port_arbiter_if.slave    bus,
  output logic             busy,
  output logic [1:0]       cur_src,
  output logic             pkt_err
);

  typedef enum logic [1:0] {ARB_IDLE, ARB_WAIT, ARB_XFER} state_t;

  localparam logic [5:0] MAX_LEN = 6'(MAXLENGTH);

  state_t     state;
  logic [1:0] last;
  logic [5:0] len_q;
  logic [5:0] beat_cnt;

`ifdef PORT_ARBITER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] wait_cnt;
`endif

  function automatic logic [1:0] next_idx(input logic [1:0] idx);
    return (idx == 2'd2) ? 2'd0 : idx + 2'd1;
  endfunction

  logic [1:0] cand0, cand1, cand2, winner;
  logic       any_req;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    cand0   = next_idx(last);
    cand1   = next_idx(cand0);
    cand2   = next_idx(cand1);
    any_req = |bus.R_req;
    winner  = cand2;
    if (bus.R_req[cand0])      winner = cand0;
    else if (bus.R_req[cand1]) winner = cand1;
  end

  logic       src_start, src_end;
  logic [7:0] src_data;
  logic [5:0] beat_next;
  logic       bad_len;

  assign src_start = bus.R_start[cur_src];
  assign src_end   = bus.R_end[cur_src];
  assign src_data  = bus.R_data[cur_src];
  // The start beat counts as beat 1; later beats saturate at 63.
  assign beat_next = (state == ARB_WAIT) ? 6'd1 :
                     (beat_cnt == 6'd63) ? 6'd63 : beat_cnt + 6'd1;
  assign bad_len   = (beat_next != len_q) || (len_q == 6'd0) || (len_q > MAX_LEN);
  assign busy      = (state != ARB_IDLE);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    bus.R_grant  <= '0;
    bus.O_valid  <= 1'b0;
    bus.O_start  <= 1'b0;
    bus.O_end    <= 1'b0;
    bus.O_data   <= '0;
    bus.O_length <= '0;
    pkt_err      <= 1'b0;
    if (!reset) begin
      state    <= ARB_IDLE;
      last     <= 2'd2;
      cur_src  <= 2'd0;
      len_q    <= '0;
      beat_cnt <= '0;
`ifdef PORT_ARBITER_TIMEOUT_EN
      wait_cnt <= '0;
`endif
    end else begin
      case (state)
        ARB_IDLE: begin
          if (any_req) begin
            cur_src     <= winner;
            len_q       <= bus.R_length[winner];
            bus.R_grant <= 3'b001 << winner;
            state       <= ARB_WAIT;
`ifdef PORT_ARBITER_TIMEOUT_EN
            wait_cnt    <= '0;
`endif
          end
        end
        ARB_WAIT, ARB_XFER: begin
          if (state == ARB_XFER || src_start) begin
            bus.O_valid  <= 1'b1;
            bus.O_start  <= (state == ARB_WAIT);
            bus.O_end    <= src_end;
            bus.O_data   <= src_data;
            bus.O_length <= len_q;
            beat_cnt     <= beat_next;
            state        <= ARB_XFER;
            if (src_end) begin
              pkt_err <= bad_len;
              last    <= cur_src;
              state   <= ARB_IDLE;
            end
          end
`ifdef PORT_ARBITER_TIMEOUT_EN
          else if (wait_cnt == TW'(TIMEOUT - 1)) begin
            pkt_err <= 1'b1;
            last    <= cur_src;
            state   <= ARB_IDLE;
          end else begin
            wait_cnt <= wait_cnt + TW'(1);
          end
`endif
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_port_arbiter.sv
// Self-checking bench for port_arbiter: per-cycle comparison against a behavioural model,
// directed packet scenarios with literal expectations, then randomized traffic.
module tb_port_arbiter;
  localparam int TIMEOUT   = 16;
  localparam int MAXLENGTH = 12;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  port_arbiter_if bus ();
  logic       busy;
  logic [1:0] cur_src;
  logic       pkt_err;

  port_arbiter #(.TIMEOUT(TIMEOUT), .MAXLENGTH(MAXLENGTH)) dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus.slave),
    .busy    (busy),
    .cur_src (cur_src),
    .pkt_err (pkt_err)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [23:0] dut_vec();
    return {bus.R_grant, bus.O_valid, bus.O_start, bus.O_end, bus.O_data, bus.O_length,
            busy, cur_src, pkt_err};
  endfunction

  always @(posedge clk) cyc++;

  // Behavioural model: phase 0 idle, 1 waiting for start, 2 transferring.
  int          m_phase, m_src, m_last, m_len, m_beats, m_wait;
  bit          m_on = 1'b0;
  logic [23:0] exp_vec;

  always @(posedge clk) begin
    logic [2:0] e_grant;
    logic       e_valid, e_start, e_end, e_err;
    logic [7:0] e_data;
    logic [5:0] e_len;
    bit         found;
    e_grant = '0; e_valid = 0; e_start = 0; e_end = 0; e_err = 0; e_data = '0; e_len = '0;
    if (!reset) begin
      m_phase = 0; m_last = 2; m_src = 0; m_len = 0; m_beats = 0; m_wait = 0; m_on = 1'b1;
    end else if (m_phase == 0) begin
      found = 1'b0;
      for (int k = 1; k <= 3; k++) begin
        int c;
        c = (m_last + k) % 3;
        if (!found && bus.R_req[c]) begin
          found = 1'b1;
          m_src = c;
          m_len = int'(bus.R_length[c]);
          e_grant[c] = 1'b1;
          m_phase = 1;
          m_wait = 0;
        end
      end
    end else if (m_phase == 2 || bus.R_start[m_src]) begin
      m_beats = (m_phase == 1) ? 1 : ((m_beats < 63) ? m_beats + 1 : 63);
      e_valid = 1'b1;
      e_start = (m_phase == 1);
      e_end   = bus.R_end[m_src];
      e_data  = bus.R_data[m_src];
      e_len   = 6'(m_len);
      m_phase = 2;
      if (e_end) begin
        e_err  = (m_beats != m_len) || (m_len == 0) || (m_len > MAXLENGTH);
        m_last = m_src;
        m_phase = 0;
      end
    end
`ifdef PORT_ARBITER_TIMEOUT_EN
    else begin
      m_wait++;
      if (m_wait == TIMEOUT) begin
        e_err = 1'b1;
        m_last = m_src;
        m_phase = 0;
      end
    end
`endif
    exp_vec = {e_grant, e_valid, e_start, e_end, e_data, e_len, (m_phase != 0), 2'(m_src), e_err};
  end

  always @(negedge clk) begin
    if (m_on) check($sformatf("cycle%0d", cyc), 64'(dut_vec()), 64'(exp_vec));
  end

  // Event logs taken from the DUT for the directed literal expectations.
  typedef struct {
    int src;
    int beats;
    bit se;
    bit err;
    bit busy;
  } pkt_t;

  int         grant_log[$];
  int         grant_cyc[$];
  int         err_cyc[$];
  pkt_t       pkt_log[$];
  logic [7:0] got_q[$];
  int         mon_beats = 0;

  always @(negedge clk) begin
    if (bus.R_grant != 3'b000) begin
      grant_log.push_back(bus.R_grant[0] ? 0 : (bus.R_grant[1] ? 1 : 2));
      grant_cyc.push_back(cyc);
    end
    if (pkt_err) err_cyc.push_back(cyc);
    if (bus.O_valid) begin
      if (bus.O_start) begin
        mon_beats = 0;
        got_q.delete();
      end
      mon_beats++;
      got_q.push_back(bus.O_data);
      if (bus.O_end)
        pkt_log.push_back('{int'(cur_src), mon_beats, bus.O_start, pkt_err, busy});
    end
  end

  // Requester driver state: 0 idle, 1 requesting, 2 granted (start delay), 3 sending beats.
  int         ds[3], plen[3], pend[3], dly[3], kk[3];
  bit         noise = 1'b0;
  logic [7:0] sent2[$];

  task automatic step();
    logic [2:0]      st, en, rq;
    logic [2:0][7:0] dt;
    @(posedge clk);
    #1;
    st = '0; en = '0; rq = '0; dt = '0;
    for (int i = 0; i < 3; i++) begin
      if (ds[i] == 1 && bus.R_grant[i]) ds[i] = 2;
      if (ds[i] == 2) begin
        if (dly[i] == 0) begin ds[i] = 3; kk[i] = 0; end
        else dly[i]--;
      end
      if (ds[i] == 3) begin
        st[i] = (kk[i] == 0);
        en[i] = (kk[i] == pend[i] - 1);
        dt[i] = 8'($urandom);
        kk[i]++;
        if (i == 2) sent2.push_back(dt[i]);
        if (en[i]) ds[i] = 0;
      end else if (ds[i] == 0 && noise) begin
        st[i] = 1'($urandom);
        en[i] = 1'($urandom);
        dt[i] = 8'($urandom);
      end
      rq[i] = (ds[i] == 1);
      bus.R_length[i] = 6'(plen[i]);
    end
    bus.R_req = rq; bus.R_start = st; bus.R_end = en; bus.R_data = dt;
  endtask

  function automatic bit all_idle();
    return ds[0] == 0 && ds[1] == 0 && ds[2] == 0;
  endfunction

  task automatic run_until_idle(input string name, input int budget);
    int n = 0;
    do begin
      step();
      n++;
    end while (!(all_idle() && !busy) && n < budget);
    check({name, "_drain"}, 64'(n < budget), 64'd1);
    step();
    step();
  endtask

  task automatic request(input int i, input int l, input int beats, input int d);
    plen[i] = l; pend[i] = beats; dly[i] = d; ds[i] = 1;
  endtask

  task automatic clear_driver();
    for (int i = 0; i < 3; i++) begin ds[i] = 0; kk[i] = 0; end
  endtask

  task automatic rand_update();
    for (int i = 0; i < 3; i++) begin
      if (ds[i] == 0 && $urandom_range(0, 7) == 0) begin
        plen[i] = ($urandom_range(0, 3) != 0) ? int'($urandom_range(1, MAXLENGTH))
                                               : int'($urandom_range(0, 20));
        pend[i] = ($urandom_range(0, 9) != 0 && plen[i] > 0) ? plen[i]
                                                             : int'($urandom_range(1, 14));
        dly[i]  = int'($urandom_range(0, 3));
        ds[i]   = 1;
      end else if (ds[i] == 1 && $urandom_range(0, 39) == 0) begin
        ds[i] = 0;
      end
    end
  endtask

  function automatic int last_pkt_field(input int which);
    if (pkt_log.size() == 0) return -1;
    case (which)
      0: return pkt_log[$].src;
      1: return pkt_log[$].beats;
      2: return int'(pkt_log[$].se);
      3: return int'(pkt_log[$].err);
      default: return int'(pkt_log[$].busy);
    endcase
  endfunction

  initial begin
    int base, mism;
    for (int i = 0; i < 3; i++) begin ds[i] = 0; plen[i] = 0; pend[i] = 1; dly[i] = 0; kk[i] = 0; end
    bus.R_req = '0; bus.R_length = '0; bus.R_start = '0; bus.R_data = '0; bus.R_end = '0;

    reset = 1'b0;
    step();
    step();
    check("reset_state", 64'(dut_vec()), 64'd0);
    reset = 1'b1;

    // All three request at once: strict 0,1,2 order after reset.
    grant_log.delete(); pkt_log.delete();
    request(0, 4, 4, 0); request(1, 5, 5, 0); request(2, 6, 6, 0);
    run_until_idle("r030", 200);
    check("r030_grant_count", 64'(grant_log.size()), 64'd3);
    check("r030_pkt_count", 64'(pkt_log.size()), 64'd3);
    for (int i = 0; i < 3; i++) begin
      if (i < grant_log.size()) check($sformatf("r030_grant%0d", i), 64'(grant_log[i]), 64'(i));
      if (i < pkt_log.size()) begin
        check($sformatf("r030_pkt%0d_beats", i), 64'(pkt_log[i].beats), 64'(4 + i));
        check($sformatf("r030_pkt%0d_err", i), 64'(pkt_log[i].err), 64'd0);
      end
    end

    // Single-beat packet from requester 1.
    request(1, 1, 1, 0);
    run_until_idle("r031", 50);
    check("r031_src", 64'(last_pkt_field(0)), 64'd1);
    check("r031_beats", 64'(last_pkt_field(1)), 64'd1);
    check("r031_start_end", 64'(last_pkt_field(2)), 64'd1);
    check("r031_err", 64'(last_pkt_field(3)), 64'd0);

    // Declared length 5, end on beat 3.
    request(0, 5, 3, 1);
    run_until_idle("r032", 50);
    check("r032_beats", 64'(last_pkt_field(1)), 64'd3);
    check("r032_err_at_end", 64'(last_pkt_field(3)), 64'd1);
    check("r032_idle_at_end", 64'(last_pkt_field(4)), 64'd0);

    // Reset during beat 2 of 6, then 0 and 2 compete.
    request(0, 6, 6, 0);
    begin
      int n = 0;
      while (kk[0] < 2 && n < 50) begin step(); n++; end
      check("r033_reach_beat2", 64'(n < 50), 64'd1);
    end
    base = pkt_log.size();
    reset = 1'b0;
    clear_driver();
    step();
    check("r033_reset_outputs", 64'(dut_vec()), 64'd0);
    reset = 1'b1;
    grant_log.delete();
    request(2, 3, 3, 0); request(0, 3, 3, 0);
    run_until_idle("r033", 100);
    check("r033_grant_count", 64'(grant_log.size()), 64'd2);
    if (grant_log.size() == 2)
      check("r033_grant_order", 64'(grant_log[0] * 10 + grant_log[1]), 64'd2);
    check("r033_no_abandoned_end", 64'(pkt_log.size() - base), 64'd2);

    // Requester 0 and 1 toggle their lines while requester 2 transfers.
    noise = 1'b1;
    sent2.delete();
    request(2, 8, 8, 1);
    run_until_idle("r035", 60);
    noise = 1'b0;
    check("r035_src", 64'(last_pkt_field(0)), 64'd2);
    check("r035_beats", 64'(last_pkt_field(1)), 64'd8);
    mism = (got_q.size() == sent2.size()) ? 0 : 100;
    for (int i = 0; i < got_q.size() && i < sent2.size(); i++)
      if (got_q[i] !== sent2[i]) mism++;
    check("r035_data_mismatch", 64'(mism), 64'd0);

`ifdef PORT_ARBITER_TIMEOUT_EN
    // Requester 0 is granted but never starts; requester 1 follows.
    grant_log.delete(); grant_cyc.delete(); err_cyc.delete();
    request(0, 4, 4, 1000); request(1, 2, 2, 0);
    begin
      int n = 0;
      while (grant_log.size() < 2 && n < 100) begin step(); n++; end
      check("r034_second_grant_seen", 64'(n < 100), 64'd1);
    end
    if (grant_log.size() >= 2 && err_cyc.size() >= 1) begin
      check("r034_first_grant", 64'(grant_log[0]), 64'd0);
      check("r034_timeout_delay", 64'(err_cyc[0] - grant_cyc[0]), 64'(TIMEOUT));
      check("r034_next_grant", 64'(grant_log[1]), 64'd1);
    end else begin
      check("r034_events_logged", 64'(err_cyc.size()), 64'd1);
    end
    ds[0] = 0;
    run_until_idle("r034", 60);
`endif

    // Randomized traffic with line noise and occasional resets.
    noise = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 499) == 0) begin
        reset = 1'b0;
        clear_driver();
        step();
        reset = 1'b1;
      end
      rand_update();
      step();
    end
    for (int i = 0; i < 3; i++) if (ds[i] == 1) ds[i] = 0;
    run_until_idle("random", 400);
    noise = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
